// File: rtl/gfx_fpint_round_encode.sv
// gfx_fpint_round_encode: three-stage round -> rnorm -> encode pipeline for float/int results
module gfx_fpint_round_encode #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_val,
    input  logic        in_slow,
    input  logic        in_zero,
    input  logic        in_guard,
    input  logic        in_round,
    input  logic        in_sticky,
    input  logic        in_overflow,
    input  logic        in_sticky_last,
    input  logic        in_round_enable,
    input  logic        in_encode_enable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);
    logic        advance;
    logic        round_up;
    logic [30:0] rounded;
    logic        s1_valid;
    logic        s1_sign;
    logic [30:0] s1_em;
    logic        s1_exp_step;
    logic        s1_ff_round;
    logic        s1_slow;
    logic        s1_zero;
    logic        s1_overflow;
    logic        s1_encode;
    logic        overflow_n;
    logic [22:0] mant_n;
    logic        s2_valid;
    logic        s2_sign;
    logic [7:0]  s2_exp;
    logic [22:0] s2_mant;
    logic        s2_slow;
    logic        s2_zero;
    logic        s2_overflow;
    logic        s2_encode;
    logic [31:0] s2_val;
    logic [31:0] encoded;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Round to nearest even on {exp, mant}; carry out of bit 30 is dropped.
    always_comb begin
        round_up = in_round_enable & in_guard & (in_round | in_sticky | in_sticky_last | in_val[0]);
        rounded  = in_val[30:0] + {30'h0, round_up};
    end

    // Rnorm: exponent bump into (or past) all-ones means overflow.
    always_comb begin
        overflow_n = s1_overflow | s1_ff_round | (s1_exp_step & (s1_em[30:23] == 8'hFF));
        mant_n     = s1_exp_step ? 23'h0 : s1_em[22:0];
    end

    // Encode: slow beats win, then overflow to infinity, then signed zero.
    always_comb begin
        s2_val  = {s2_sign, s2_exp, s2_mant};
        encoded = !s2_encode  ? s2_val :
                  s2_slow     ? CANON_NAN :
                  s2_overflow ? {s2_sign, 8'hFF, 23'h0} :
                  s2_zero     ? {s2_sign, 31'h0} : s2_val;
    end

    // Valid bits and the output word reset asynchronously; all hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            out_word  <= encoded;
        end
    end

    // Stage data registers need no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign     <= in_val[31];
            s1_em       <= rounded;
            s1_exp_step <= (&in_val[22:0]) & round_up;
            s1_ff_round <= (in_val[30:23] == 8'hFF) & round_up;
            s1_slow     <= in_slow;
            s1_zero     <= in_zero;
            s1_overflow <= in_overflow;
            s1_encode   <= in_encode_enable;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_em[30:23];
            s2_mant     <= mant_n;
            s2_slow     <= s1_slow;
            s2_zero     <= s1_zero;
            s2_overflow <= overflow_n;
            s2_encode   <= s1_encode;
        end
    end
endmodule
